// File: rtl/axis_uart_tx.sv
// AXI-Stream byte to 8N1 UART serialiser with one-byte holding register.
// Optional LF->CRLF expansion is compiled in when AXIS_UART_CRLF_EN is defined.
module axis_uart_tx #(
    parameter int unsigned CLOCKS_PER_BIT = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tkeep,
    input  logic [7:0] s_tdata,
    output logic       uart_tx_o,
    output logic       busy_o,
    output logic       last_o
);

    localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef AXIS_UART_CRLF_EN
        , GAP
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    data_q, data_n;
    logic          tlast_q, tlast_n;
    logic          tx_n, ready_n, last_n;
    logic          bit_end;
`ifdef AXIS_UART_CRLF_EN
    logic          crlf_q, crlf_n;
`endif

    assign bit_end = (cnt == CNT_MAX);
    assign busy_o  = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        data_n  = data_q;
        tlast_n = tlast_q;
        last_n  = 1'b0;
`ifdef AXIS_UART_CRLF_EN
        crlf_n  = crlf_q;
`endif
        case (state)
            IDLE: begin
                if (s_tvalid && s_tready && s_tkeep) begin
                    data_n  = s_tdata;
                    tlast_n = s_tlast;
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = START;
`ifdef AXIS_UART_CRLF_EN
                    if (s_tdata == 8'h0A) begin
                        data_n = 8'h0D;
                        crlf_n = 1'b1;
                    end
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
`ifdef AXIS_UART_CRLF_EN
                    // CR frame done: reload the LF and defer the tlast pulse
                    if (crlf_q) begin
                        state_n = GAP;
                        data_n  = 8'h0A;
                        crlf_n  = 1'b0;
                    end else
`endif
                    begin
                        state_n = IDLE;
                        last_n  = tlast_q;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef AXIS_UART_CRLF_EN
            GAP: begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = START;
            end
`endif
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_n[bit_n];
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            tlast_q   <= 1'b0;
            s_tready  <= 1'b0;
            uart_tx_o <= 1'b1;
            last_o    <= 1'b0;
`ifdef AXIS_UART_CRLF_EN
            crlf_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            data_q    <= data_n;
            tlast_q   <= tlast_n;
            s_tready  <= ready_n;
            uart_tx_o <= tx_n;
            last_o    <= last_n;
`ifdef AXIS_UART_CRLF_EN
            crlf_q    <= crlf_n;
`endif
        end
    end

endmodule
